// File: rtl/cpu_defs.sv
// ============================================================================
// Module   : cpu_defs
// Purpose  : Shared RV32 pipeline definitions for the execute-stage shift slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam int XLEN    = 32;
    localparam int RD_W    = 5;
    localparam int SHAMT_W = 5;

    // Encoding 2'b10 is reserved and executes as a left shift.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_RSV = 2'b10,
        SH_SRA = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            we;
    } ex_payload_t;

endpackage

`default_nettype wire

// File: rtl/ex_shift_stage_shifter.sv
// ============================================================================
// Module   : ex_shift_stage_shifter
// Purpose  : Combinational barrel shifter (left, logical right, arithmetic right).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_shift_stage_shifter #(
    parameter int XLEN = 32,
    parameter int SA_W = 5
) (
    input  logic [XLEN-1:0] data,
    input  logic [SA_W-1:0] sa,
    input  logic            right,
    input  logic            arith,
    output logic [XLEN-1:0] result
);

    // Kept in its own signed net so the ternary below cannot strip signedness.
    logic signed [XLEN-1:0] w_sra;
    logic        [XLEN-1:0] w_srl;
    logic        [XLEN-1:0] w_sll;

    assign w_sra = $signed(data) >>> sa;
    assign w_srl = data >> sa;
    assign w_sll = data << sa;

    always_comb begin
        result = w_sll;
        if (right) begin
            result = arith ? w_sra : w_srl;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_shift_stage.sv
// ============================================================================
// Module   : ex_shift_stage
// Purpose  : EX shift slot with 2-entry skid buffer into the EX/MEM boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_shift_stage
    import cpu_defs::*;
#(
    parameter int XLEN = cpu_defs::XLEN,
    parameter int RD_W = cpu_defs::RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_imm_sh,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_we,
    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            we;
    } payload_t;

    shift_op_e       w_op;
    logic            w_right;
    logic            w_arith;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_shift_res;
    logic            w_accept;
    logic            w_drain;
    logic            w_main_free;
    logic            w_unused;
    payload_t        w_new;

    logic            r_out_valid;
    logic            r_skid_valid;
    payload_t        r_main;
    payload_t        r_skid;

    assign w_op     = shift_op_e'(in_op);
    assign w_right  = (w_op == SH_SRL) || (w_op == SH_SRA);
    assign w_arith  = (w_op == SH_SRA);
    assign w_shamt  = in_use_imm ? in_imm_sh : in_rs2[4:0];
    assign w_unused = ^in_rs2[XLEN-1:5];

    ex_shift_stage_shifter #(
        .XLEN (XLEN),
        .SA_W (5)
    ) u_shifter (
        .data   (in_rs1),
        .sa     (w_shamt),
        .right  (w_right),
        .arith  (w_arith),
        .result (w_shift_res)
    );

    assign w_new.result = w_shift_res;
    assign w_new.rd     = in_rd;
    assign w_new.we     = (in_rd != '0);

    // in_ready is a flop output: the skid slot being empty is the only gate.
    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & in_ready;
    assign w_drain     = r_out_valid & out_ready;
    assign w_main_free = ~r_out_valid | w_drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid  <= w_accept;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Payload registers ignore flush; consumers qualify on out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    r_main <= r_skid;
                end else if (w_accept) begin
                    r_main <= w_new;
                end
            end else if (w_accept) begin
                r_skid <= w_new;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_main.result;
    assign out_rd     = r_main.rd;
    assign out_we     = r_main.we;

    assign fwd_valid  = r_out_valid & r_main.we;
    assign fwd_rd     = r_main.rd;
    assign fwd_data   = r_main.result;

endmodule

`default_nettype wire

// File: tb/tb_ex_shift_stage.sv
// ============================================================================
// Module   : tb_ex_shift_stage
// Purpose  : Scoreboard bench for the EX shift slot and its skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_shift_stage;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_use_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_imm_sh;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int   n_checks;
    int   n_fail;
    int   n_out;
    exp_t sb[$];

    ex_shift_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_use_imm (in_use_imm),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm_sh  (in_imm_sh),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] rs1,
                                   input logic [4:0] sh, input logic [4:0] rd);
        exp_t e;
        case (op)
            2'b01:   e.result = rs1 >> sh;
            2'b11: begin
                for (int i = 0; i < 32; i++)
                    e.result[i] = (i + int'(sh) < 32) ? rs1[i + int'(sh)] : rs1[31];
            end
            default: e.result = rs1 << sh;
        endcase
        e.rd = rd;
        e.we = (rd != 5'd0);
        return e;
    endfunction

    function automatic exp_t cur_exp();
        return model(in_op, in_rs1, in_use_imm ? in_imm_sh : in_rs2[4:0], in_rd);
    endfunction

    task automatic drive(input logic [1:0] op, input logic use_imm, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [4:0] imm, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_op      = op;
        in_use_imm = use_imm;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm_sh  = imm;
        in_rd      = rd;
    endtask

    // Book-keeps both handshakes for the coming edge, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    check("sb_result", out_result, e.result);
                    check("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    check("sb_we", {31'd0, out_we}, {31'd0, e.we});
                    check("sb_fwd_valid", {31'd0, fwd_valid}, {31'd0, e.we});
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_t ea;
        int   base;
        n_checks = 0; n_fail = 0; n_out = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'b00; in_use_imm = 1'b0; in_rs1 = '0; in_rs2 = '0; in_imm_sh = '0; in_rd = '0;
        @(negedge clk); @(negedge clk);

        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_we", {31'd0, out_we}, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // SRA by immediate
        drive(2'b11, 1'b1, 32'h8000_0000, 32'h0, 5'd4, 5'd5);
        tick();
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_result", out_result, 32'hF800_0000);
        check("t1_we", {31'd0, out_we}, 32'd1);
        check("t1_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("t1_fwd_rd", {27'd0, fwd_rd}, 32'd5);
        check("t1_fwd_data", fwd_data, 32'hF800_0000);

        // Register shamt ignores rs2[31:5]; SRL by 31
        drive(2'b00, 1'b0, 32'h0000_0001, 32'hFFFF_FFE5, 5'd0, 5'd7);
        tick();
        check("t2_sll", out_result, 32'h0000_0020);
        drive(2'b01, 1'b0, 32'h8000_0000, 32'd31, 5'd0, 5'd8);
        tick();
        check("t2_srl", out_result, 32'h0000_0001);
        drive(2'b10, 1'b1, 32'h0000_0003, 32'h0, 5'd2, 5'd9);
        tick();
        check("t2_reserved_as_sll", out_result, 32'h0000_000C);
        in_valid = 1'b0;
        tick();

        // Backpressure: A in main, B in skid, C held
        out_ready = 1'b0;
        base = n_out;
        drive(2'b00, 1'b1, 32'h0000_00A0, 32'h0, 5'd1, 5'd1);
        ea = cur_exp();
        tick();
        check("t3_in_ready_one", {31'd0, in_ready}, 32'd1);
        drive(2'b01, 1'b1, 32'h0000_0B00, 32'h0, 5'd4, 5'd2);
        tick();
        check("t3_in_ready_two", {31'd0, in_ready}, 32'd0);
        check("t3_hold_a", out_result, ea.result);
        drive(2'b11, 1'b1, 32'hC000_0000, 32'h0, 5'd8, 5'd3);
        tick();
        check("t3_c_held", {31'd0, in_ready}, 32'd0);
        check("t3_hold_a_stable", out_result, ea.result);
        check("t3_hold_a_rd", {27'd0, out_rd}, 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        check("t3_three_out", n_out - base, 32'd3);
        check("t3_sb_empty", sb.size(), 32'd0);

        // Flush with two held ops and a presented op
        out_ready = 1'b0;
        drive(2'b00, 1'b1, 32'h1111_1111, 32'h0, 5'd1, 5'd4);
        tick();
        drive(2'b00, 1'b1, 32'h2222_2222, 32'h0, 5'd1, 5'd6);
        tick();
        drive(2'b00, 1'b1, 32'h3333_3333, 32'h0, 5'd1, 5'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_out_valid", {31'd0, out_valid}, 32'd0);
        check("t4_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // rd == 0 still flows, no write
        drive(2'b00, 1'b1, 32'h0000_1234, 32'h0, 5'd4, 5'd0);
        tick();
        check("t5_out_valid", {31'd0, out_valid}, 32'd1);
        check("t5_result", out_result, 32'h0001_2340);
        check("t5_we", {31'd0, out_we}, 32'd0);
        check("t5_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset with two ops in flight
        out_ready = 1'b0;
        drive(2'b01, 1'b1, 32'hFFFF_0000, 32'h0, 5'd4, 5'd11);
        tick();
        drive(2'b01, 1'b1, 32'hFFFF_0000, 32'h0, 5'd8, 5'd12);
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_async_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_async_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(2'b11, 1'b0, 32'h8765_4321, 32'd12, 5'd0, 5'd13);
        tick();
        check("t6_post_valid", {31'd0, out_valid}, 32'd1);
        check("t6_post_result", out_result, 32'hFFF8_7654);
        in_valid = 1'b0;
        tick();

        // Random traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = 2'($urandom_range(0, 3));
            in_use_imm = 1'($urandom_range(0, 1));
            in_rs1     = $urandom;
            in_rs2     = $urandom;
            in_imm_sh  = 5'($urandom_range(0, 31));
            in_rd      = 5'($urandom_range(0, 31));
            out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        check("final_drain", sb.size(), 32'd0);
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
